// File: rtl/fp_accumulator.sv
// fp_accumulator: sums a stream of fp13 values (sign | exp[3:0] bias 7 | frac[7:0])
// into an internal accumulator. Each group ends with a word marked last; its sum is
// presented on the output port and the accumulator is cleared for the next group.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | in_ready high, waiting for an operand
// ALIGN  | right-shift the smaller-exponent significand; zero operands bypass
// ADD    | signed-magnitude add/subtract of aligned significands
// NORM   | one normalization step per cycle, saturate or flush as needed
// COMMIT | write result to accumulator, or publish it on the last term
// OUT    | hold the group sum until out_ready
module fp_accumulator #(
   parameter int MAX_NORM_SHIFT = 11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [12:0] in_fp,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [12:0] out_fp,
   output logic        out_overflow
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_COMMIT,
      S_OUT
   } state_t;

   state_t      state;
   logic [12:0] acc;
   logic        ovf_flag;
   logic [12:0] opnd;
   logic        last_q;
   logic [11:0] sig_a;
   logic [11:0] sig_b;
   logic        sgn_a;
   logic        sgn_b;
   logic [3:0]  exp_r;
   logic [12:0] sum;
   logic        sgn;
   logic [7:0]  steps;
   logic [12:0] res;

   // ALIGN datapath: exponent difference and shifted significands
   logic [3:0]  ea;
   logic [3:0]  eb;
   logic [3:0]  diff;
   logic [3:0]  big_exp;
   logic [11:0] sig_acc;
   logic [11:0] sig_op;
   logic [11:0] al_a;
   logic [11:0] al_b;
   logic        acc_zero;
   logic        op_zero;

   // Exponent 0 is reserved for zero, so any word with it (including -0) counts as zero
   always_comb begin
      ea       = acc[11:8];
      eb       = opnd[11:8];
      acc_zero = (ea == 4'd0);
      op_zero  = (eb == 4'd0);
      sig_acc  = {1'b1, acc[7:0], 3'b000};
      sig_op   = {1'b1, opnd[7:0], 3'b000};
      diff     = 4'd0;
      big_exp  = ea;
      al_a     = sig_acc;
      al_b     = sig_op;
      if (ea >= eb) begin
         diff    = ea - eb;
         big_exp = ea;
         al_a    = sig_acc;
         al_b    = (diff >= 4'd12) ? 12'd0 : (sig_op >> diff);
      end else begin
         diff    = eb - ea;
         big_exp = eb;
         al_a    = (diff >= 4'd12) ? 12'd0 : (sig_acc >> diff);
         al_b    = sig_op;
      end
   end

   // ADD datapath: larger magnitude sets the sign, subtract smaller from larger
   logic        a_ge_b;
   logic [12:0] add_sum;
   logic        add_sgn;

   always_comb begin
      a_ge_b  = (sig_a >= sig_b);
      add_sgn = a_ge_b ? sgn_a : sgn_b;
      if (sgn_a == sgn_b) begin
         add_sum = {1'b0, sig_a} + {1'b0, sig_b};
      end else if (a_ge_b) begin
         add_sum = {1'b0, sig_a} - {1'b0, sig_b};
      end else begin
         add_sum = {1'b0, sig_b} - {1'b0, sig_a};
      end
   end

   // NORM helper: the candidate one-position left shift
   logic [12:0] shl;

   always_comb begin
      shl = {sum[11:0], 1'b0};
   end

   // Controller FSM with registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         acc          <= 13'd0;
         ovf_flag     <= 1'b0;
         opnd         <= 13'd0;
         last_q       <= 1'b0;
         sig_a        <= 12'd0;
         sig_b        <= 12'd0;
         sgn_a        <= 1'b0;
         sgn_b        <= 1'b0;
         exp_r        <= 4'd0;
         sum          <= 13'd0;
         sgn          <= 1'b0;
         steps        <= 8'd0;
         res          <= 13'd0;
         in_ready     <= 1'b0;
         out_valid    <= 1'b0;
         out_fp       <= 13'd0;
         out_overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  opnd     <= in_fp;
                  last_q   <= in_last;
                  in_ready <= 1'b0;
                  state    <= S_ALIGN;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            S_ALIGN: begin
               if (acc_zero || op_zero) begin
                  // Zero on either side: the other value passes; zero+zero is +0
                  if (acc_zero) begin
                     res <= op_zero ? 13'd0 : opnd;
                  end else begin
                     res <= acc;
                  end
                  state <= S_COMMIT;
               end else begin
                  sig_a <= al_a;
                  sig_b <= al_b;
                  sgn_a <= acc[12];
                  sgn_b <= opnd[12];
                  exp_r <= big_exp;
                  state <= S_ADD;
               end
            end
            S_ADD: begin
               sum   <= add_sum;
               sgn   <= add_sgn;
               steps <= 8'd0;
               state <= S_NORM;
            end
            S_NORM: begin
               if (sum == 13'd0) begin
                  res   <= 13'd0;
                  state <= S_COMMIT;
               end else if (sum[12]) begin
                  if (exp_r == 4'd15) begin
                     res      <= {sgn, 4'hF, 8'hFF};
                     ovf_flag <= 1'b1;
                  end else begin
                     res <= {sgn, exp_r + 4'd1, sum[11:4]};
                  end
                  state <= S_COMMIT;
               end else if (sum[11]) begin
                  res   <= {sgn, exp_r, sum[10:3]};
                  state <= S_COMMIT;
               end else if ((exp_r <= 4'd1) || (steps >= 8'(MAX_NORM_SHIFT))) begin
                  // Underflow or runaway normalization flushes to +0
                  res   <= 13'd0;
                  state <= S_COMMIT;
               end else begin
                  // Finish in the same cycle the leading one reaches bit 11
                  sum   <= shl;
                  exp_r <= exp_r - 4'd1;
                  steps <= steps + 8'd1;
                  if (shl[11]) begin
                     res   <= {sgn, exp_r - 4'd1, shl[10:3]};
                     state <= S_COMMIT;
                  end
               end
            end
            S_COMMIT: begin
               if (last_q) begin
                  out_fp       <= res;
                  out_overflow <= ovf_flag;
                  out_valid    <= 1'b1;
                  acc          <= 13'd0;
                  ovf_flag     <= 1'b0;
                  state        <= S_OUT;
               end else begin
                  acc      <= res;
                  in_ready <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator with hand-computed fp13 sums.
module tb_fp_accumulator;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [12:0] in_fp;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [12:0] out_fp;
   logic        out_overflow;

   int total = 0;
   int bad   = 0;
   int cyc;
   logic [12:0] sat_exp [4];

   fp_accumulator #(.MAX_NORM_SHIFT(11)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_fp        (in_fp),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_fp       (out_fp),
      .out_overflow (out_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Wait (bounded) for in_ready at a negedge, then present one word for one cycle
   task automatic send(input logic [12:0] v, input logic l);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_fp    = v;
      in_last  = l;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_fp    = 13'd0;
   endtask

   // Cycles from the transfer cycle until in_ready is high again
   task automatic wait_ready(output int c);
      c = 1;
      while (in_ready !== 1'b1 && c < 100) begin
         @(negedge clk);
         c++;
      end
      if (c >= 100) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
   endtask

   // Cycles from the transfer cycle of the last term until out_valid is high
   task automatic wait_out(output int c);
      c = 1;
      while (out_valid !== 1'b1 && c < 100) begin
         @(negedge clk);
         c++;
      end
      if (c >= 100) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic take_out(input string tag, input logic [12:0] f, input logic o);
      chk({tag, "_fp"}, {19'd0, out_fp}, {19'd0, f});
      chk({tag, "_ovf"}, {31'd0, out_overflow}, {31'd0, o});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_clr"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_fp     = 13'd0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      sat_exp[0] = 13'h0EFC;
      sat_exp[1] = 13'h0F7D;
      sat_exp[2] = 13'h0FFC;
      sat_exp[3] = 13'h0FFF;

      // Reset values
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_fp", {19'd0, out_fp}, 32'd0);
      chk("rst_out_ovf", {31'd0, out_overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

      // Basic sum 1 + 3 = 4
      send(13'h0700, 1'b0);
      wait_ready(cyc);
      send(13'h0880, 1'b1);
      wait_out(cyc);
      chk("basic_lat", cyc, 32'd5);
      take_out("basic", 13'h0900, 1'b0);

      // Accumulate 0x0DFC (127) repeatedly, ending in saturation
      for (int g = 0; g < 4; g++) begin
         for (int t = 0; t <= g + 1; t++) begin
            send(13'h0DFC, (t == g + 1));
            if (t != g + 1) begin
               wait_ready(cyc);
               if (t > 0) chk("sat_spacing", cyc, 32'd5);
            end
         end
         wait_out(cyc);
         chk("sat_lat", cyc, 32'd5);
         take_out("sat", sat_exp[g], (g == 3));
      end
      send(13'h0700, 1'b1);
      wait_out(cyc);
      take_out("after_sat", 13'h0700, 1'b0);

      // Exact cancellation and 6-step normalization
      send(13'h0880, 1'b0);
      wait_ready(cyc);
      send(13'h1880, 1'b1);
      wait_out(cyc);
      chk("cancel_lat", cyc, 32'd5);
      take_out("cancel", 13'h0000, 1'b0);
      send(13'h0DFC, 1'b0);
      wait_ready(cyc);
      send(13'h1DF8, 1'b1);
      wait_out(cyc);
      chk("norm6_lat", cyc, 32'd10);
      take_out("norm6", 13'h0700, 1'b0);

      // Single-term groups
      send(13'h1000, 1'b1);
      wait_out(cyc);
      take_out("neg_zero", 13'h0000, 1'b0);
      send(13'h1234, 1'b1);
      wait_out(cyc);
      take_out("single", 13'h1234, 1'b0);

      // Backpressure: output held, input refused while in OUT
      send(13'h0700, 1'b1);
      wait_out(cyc);
      for (int i = 0; i < 10; i++) begin
         chk("bp_fp", {19'd0, out_fp}, 32'h0700);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         in_valid = (i == 4);
         in_fp    = 13'h0880;
         in_last  = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
      take_out("bp", 13'h0700, 1'b0);
      chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
      send(13'h0300, 1'b1);
      wait_out(cyc);
      take_out("bp_next", 13'h0300, 1'b0);

      // Alignment drop with a zero operand in the middle
      send(13'h0F00, 1'b0);
      wait_ready(cyc);
      send(13'h0000, 1'b0);
      wait_ready(cyc);
      send(13'h0300, 1'b1);
      wait_out(cyc);
      take_out("align_drop", 13'h0F00, 1'b0);

      // Reset during OUT drops the pending sum immediately
      send(13'h0880, 1'b1);
      wait_out(cyc);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid_now", {31'd0, out_valid}, 32'd0);
      chk("rst_out_fp_now", {19'd0, out_fp}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset mid-NORM discards the partial sum
      send(13'h0DFC, 1'b0);
      wait_ready(cyc);
      send(13'h1DF8, 1'b1);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_norm_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_norm_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_norm_rel_ready", {31'd0, in_ready}, 32'd1);
      send(13'h0700, 1'b1);
      wait_out(cyc);
      take_out("rst_norm_next", 13'h0700, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
